// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the error-response state type used by the
// multiplier register-file slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ERR_IDLE   = 2'd0,
    ERR_FIRST  = 2'd1,
    ERR_SECOND = 2'd2
  } errState_e;

  // Completed-multiply counter increments but sticks at all-ones.
  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ahb_mul_iter.sv
// Iterative unsigned 32x32 shift-add multiplier retiring MUL_BITS multiplier
// bits per cycle; p carries the full 64-bit product during the done cycle.
module ahb_mul_iter #(
  parameter int unsigned MUL_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] p
);

  localparam int unsigned L  = 32 / MUL_BITS;
  localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;

  logic [63:0]   mcand_q;
  logic [31:0]   mplier_q;
  logic [63:0]   prod_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [63:0]   partial;
  logic [63:0]   prod_d;

  always_comb begin
    partial = '0;
    for (int j = 0; j < int'(MUL_BITS); j++) begin
      if (mplier_q[j]) begin
        partial = partial + (mcand_q << j);
      end
    end
    prod_d = prod_q + partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start && !busy_q) begin
      mcand_q  <= {32'd0, a};
      mplier_q <= b;
      prod_q   <= '0;
      cnt_q    <= CW'(L - 1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      prod_q   <= prod_d;
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);
  assign p    = prod_d;

endmodule

// File: rtl/ahb_mul_regfile.sv
// AHB-Lite slave: word register file whose data-register writes multiply into
// a running-product accumulator, with wait states while the multiplier runs.
module ahb_mul_regfile
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned MUL_BITS = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] M_AHB_0_haddr,
  input  logic [1:0]  M_AHB_0_htrans,
  input  logic        M_AHB_0_hwrite,
  input  logic [2:0]  M_AHB_0_hsize,
  input  logic [2:0]  M_AHB_0_hburst,
  input  logic [3:0]  M_AHB_0_hprot,
  input  logic        M_AHB_0_hmastlock,
  input  logic [31:0] M_AHB_0_hwdata,
  output logic [31:0] M_AHB_0_hrdata,
  output logic        M_AHB_0_hready,
  output logic        M_AHB_0_hresp,
  output logic [3:0]  led
);

  localparam int unsigned IW = $clog2(NUM_REGS + 2);
  localparam int unsigned RW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] ACC_IDX    = IW'(NUM_REGS);
  localparam logic [IW-1:0] STATUS_IDX = IW'(NUM_REGS + 1);

  logic [IW-1:0] addrIdx;
  logic          addrSel;
  logic          addrLegal;
  logic          unusedInputs;

  logic          dValid_q;
  logic          dWrite_q;
  logic [IW-1:0] dIdx_q;
  errState_e     errState_q;

  logic [31:0]   regs_q [NUM_REGS];
  logic [31:0]   acc_q, acc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          dIsData, dIsAcc, dIsStatus;
  logic          stall, hreadyOut, xferDone;
  logic          regWrite, accWrite, statusClr;
  logic          mulBusy, mulDone;
  logic [63:0]   mulP;

  assign addrIdx   = M_AHB_0_haddr[IW+1:2];
  assign addrSel   = hreadyOut &&
                     (M_AHB_0_htrans == HTRANS_NONSEQ || M_AHB_0_htrans == HTRANS_SEQ);
  assign addrLegal = (addrIdx <= STATUS_IDX) && (M_AHB_0_hsize == HSIZE_WORD);

  assign unusedInputs = ^{M_AHB_0_hburst, M_AHB_0_hprot, M_AHB_0_hmastlock,
                          M_AHB_0_haddr[31:IW+2], M_AHB_0_haddr[1:0]};

  assign dIsData   = dIdx_q < ACC_IDX;
  assign dIsAcc    = dIdx_q == ACC_IDX;
  assign dIsStatus = dIdx_q == STATUS_IDX;

  // Anything touching ACC, or launching a new multiply, waits for the multiplier.
  assign stall     = dValid_q && mulBusy && (dIsAcc || (dIsData && dWrite_q));
  assign hreadyOut = !stall && (errState_q != ERR_FIRST);
  assign xferDone  = dValid_q && !stall;

  assign regWrite  = xferDone && dWrite_q && dIsData;
  assign accWrite  = xferDone && dWrite_q && dIsAcc;
  assign statusClr = xferDone && dWrite_q && dIsStatus;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dValid_q <= 1'b0;
      dWrite_q <= 1'b0;
      dIdx_q   <= '0;
    end else if (hreadyOut) begin
      dValid_q <= addrSel && addrLegal;
      dWrite_q <= M_AHB_0_hwrite;
      dIdx_q   <= addrIdx;
    end
  end

  // Illegal address phases are answered with the two-cycle ERROR sequence.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      errState_q <= ERR_IDLE;
    end else begin
      case (errState_q)
        ERR_FIRST: errState_q <= ERR_SECOND;
        default:   errState_q <= (addrSel && !addrLegal) ? ERR_FIRST : ERR_IDLE;
      endcase
    end
  end

  ahb_mul_iter #(
    .MUL_BITS(MUL_BITS)
  ) u_mul (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .start(regWrite),
    .a    (acc_q),
    .b    (M_AHB_0_hwdata),
    .busy (mulBusy),
    .done (mulDone),
    .p    (mulP)
  );

  // A STATUS clear landing on the final multiply cycle still counts that product.
  always_comb begin
    acc_d = acc_q;
    cnt_d = statusClr ? 16'd0 : cnt_q;
    ovf_d = statusClr ? 1'b0 : ovf_q;
    if (accWrite) begin
      acc_d = M_AHB_0_hwdata;
    end else if (mulDone) begin
      acc_d = mulP[31:0];
    end
    if (mulDone) begin
      cnt_d = satInc16(cnt_d);
      ovf_d = ovf_d || (mulP[63:32] != 32'd0);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc_q <= 32'd1;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (regWrite) begin
      regs_q[dIdx_q[RW-1:0]] <= M_AHB_0_hwdata;
    end
  end

  always_comb begin
    M_AHB_0_hrdata = '0;
    if (dValid_q && !dWrite_q) begin
      if (dIsData) begin
        M_AHB_0_hrdata = regs_q[dIdx_q[RW-1:0]];
      end else if (dIsAcc) begin
        M_AHB_0_hrdata = acc_q;
      end else begin
        M_AHB_0_hrdata = {8'd0, cnt_q, 6'd0, ovf_q, mulBusy};
      end
    end
  end

  assign M_AHB_0_hready = hreadyOut;
  assign M_AHB_0_hresp  = (errState_q == ERR_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  assign led            = regs_q[0][3:0];

endmodule
